// File: rtl/bus_arbiter_2to1.sv
// bus_arbiter_2to1
//   Round-robin arbiter for a shared 16-bit bus with two requesters. It drives
//   the select line of the 2:1 data mux, issues registered grants, and registers
//   the selected word onto BusOut together with a valid flag. Ownership is
//   bounded: while the other side is requesting, an owner can keep the bus for
//   at most MAX_HOLD consecutive cycles.
// Ports
//   Clock    in   rising-edge clock
//   Resetn   in   asynchronous active-low reset
//   Req0/1   in   bus requests, held high while the bus is needed
//   Data0/1  in   requester data, which must be valid whenever its grant is high
//   Gnt0/1   out  registered grants, one-hot or both low
//   Sel      out  mux select (0 = Data0, 1 = Data1)
//   BusOut   out  registered muxed word
//   BusValid out  BusOut was captured under a grant in the previous cycle
module bus_arbiter_2to1 #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned MAX_HOLD = 8,
  parameter int unsigned CW       = 4
) (
  input  logic             Clock,
  input  logic             Resetn,
  input  logic             Req0,
  input  logic             Req1,
  input  logic [WIDTH-1:0] Data0,
  input  logic [WIDTH-1:0] Data1,
  output logic             Gnt0,
  output logic             Gnt1,
  output logic             Sel,
  output logic [WIDTH-1:0] BusOut,
  output logic             BusValid
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD - 1);

  state_t           state_q, state_d;
  logic             last_q, last_d;   // 0: requester 0 owned most recently
  logic [CW-1:0]    hold_q, hold_d;
  logic [WIDTH-1:0] bus_q;
  logic             valid_q;
  logic             contended;

  // The non-owner is currently asking for the bus.
  assign contended = ((state_q == OWN0) && Req1) || ((state_q == OWN1) && Req0);

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    hold_d  = hold_q;

    unique case (state_q)
      IDLE: begin
        if (Req0 && Req1)  state_d = last_q ? OWN0 : OWN1;
        else if (Req0)     state_d = OWN0;
        else if (Req1)     state_d = OWN1;
      end
      OWN0: begin
        if (!Req0)                           state_d = Req1 ? OWN1 : IDLE;
        else if (Req1 && hold_q == HOLD_LAST) state_d = OWN1;
      end
      OWN1: begin
        if (!Req1)                           state_d = Req0 ? OWN0 : IDLE;
        else if (Req0 && hold_q == HOLD_LAST) state_d = OWN0;
      end
      default: state_d = IDLE;
    endcase

    // The counter measures the current tenure only, so any change of owner
    // (including a handoff) starts it again from zero.
    if (state_d != state_q) begin
      hold_d = '0;
      if (state_d == OWN0)      last_d = 1'b0;
      else if (state_d == OWN1) last_d = 1'b1;
    end else if (contended && hold_q != HOLD_LAST) begin
      hold_d = hold_q + 1'b1;
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
    end
  end

  assign Gnt0 = (state_q == OWN0);
  assign Gnt1 = (state_q == OWN1);
  assign Sel  = Gnt1;

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      bus_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= Gnt0 | Gnt1;
      if (Gnt0 | Gnt1) bus_q <= Sel ? Data1 : Data0;
    end
  end

  assign BusOut   = bus_q;
  assign BusValid = valid_q;

endmodule

// File: tb/tb_bus_arbiter_2to1.sv
module tb_bus_arbiter_2to1;

  localparam int MAX_HOLD = 8;

  logic        Clock;
  logic        Resetn;
  logic        Req0, Req1;
  logic [15:0] Data0, Data1;
  logic        Gnt0, Gnt1, Sel, BusValid;
  logic [15:0] BusOut;

  int checks   = 0;
  int failures = 0;

  bus_arbiter_2to1 #(.WIDTH(16), .MAX_HOLD(MAX_HOLD), .CW(4)) dut (
    .Clock(Clock), .Resetn(Resetn), .Req0(Req0), .Req1(Req1),
    .Data0(Data0), .Data1(Data1), .Gnt0(Gnt0), .Gnt1(Gnt1), .Sel(Sel),
    .BusOut(BusOut), .BusValid(BusValid)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Reference model: owner -1/0/1, who owned last, and how many edges of the
  // current tenure saw the other side waiting.
  int          m_owner;
  int          m_last;
  int          m_cont;
  logic [15:0] m_bus;
  logic        m_valid;

  task automatic model_reset();
    m_owner = -1; m_last = 1; m_cont = 0; m_bus = '0; m_valid = 1'b0;
  endtask

  task automatic model_edge(input logic r0, input logic r1,
                            input logic [15:0] d0, input logic [15:0] d1);
    bit req [2];
    int nxt;
    req[0] = r0; req[1] = r1;
    m_valid = (m_owner >= 0);
    if (m_owner >= 0) m_bus = (m_owner == 1) ? d1 : d0;
    if (m_owner < 0) begin
      if (r0 && r1)  nxt = 1 - m_last;
      else if (r0)   nxt = 0;
      else if (r1)   nxt = 1;
      else           nxt = -1;
    end else begin
      int o = m_owner;
      int t = 1 - m_owner;
      if (!req[o])                               nxt = req[t] ? t : -1;
      else if (req[t] && m_cont >= MAX_HOLD - 1) nxt = t;
      else                                       nxt = o;
    end
    if (nxt == m_owner) begin
      if (m_owner >= 0 && req[1 - m_owner]) m_cont++;
    end else begin
      m_cont = 0;
    end
    if (nxt >= 0 && nxt != m_owner) m_last = nxt;
    m_owner = nxt;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: inputs already applied are seen at the edge; sample 1 time unit later.
  task automatic step();
    logic r0, r1;
    logic [15:0] d0, d1;
    r0 = Req0; r1 = Req1; d0 = Data0; d1 = Data1;
    @(posedge Clock);
    model_edge(r0, r1, d0, d1);
    #1;
  endtask

  task automatic do_reset(input bit check_it);
    Resetn = 1'b0; Req0 = 1'b0; Req1 = 1'b0; Data0 = '0; Data1 = '0;
    @(posedge Clock);
    #1;
    if (check_it) begin
      chk("rst_gnt0", Gnt0, 0);
      chk("rst_gnt1", Gnt1, 0);
      chk("rst_sel", Sel, 0);
      chk("rst_valid", BusValid, 0);
      chk("rst_bus", BusOut, 0);
    end
    Resetn = 1'b1;
    model_reset();
  endtask

  typedef struct {
    logic        r0, r1;
    logic [15:0] d0, d1;
    logic        g0, g1, sel, valid;
    logic [15:0] bus;
  } vec_t;

  vec_t vecs [12];

  initial begin
    int wait0, wait1;
    logic [15:0] last_d1;

    //            r0 r1  d0       d1       g0 g1 sel vld bus
    vecs[0]  = '{1, 0, 16'hA5A5, 16'h0000, 1, 0, 0, 0, 16'h0000};
    vecs[1]  = '{1, 0, 16'hA5A5, 16'h0000, 1, 0, 0, 1, 16'hA5A5};
    vecs[2]  = '{1, 1, 16'h1111, 16'h2222, 1, 0, 0, 1, 16'h1111};
    vecs[3]  = '{0, 1, 16'h4444, 16'h3333, 0, 1, 1, 1, 16'h4444};
    vecs[4]  = '{0, 0, 16'h0000, 16'h5555, 0, 0, 0, 1, 16'h5555};
    vecs[5]  = '{0, 0, 16'h6666, 16'h6666, 0, 0, 0, 0, 16'h5555};
    vecs[6]  = '{1, 1, 16'h0101, 16'h0202, 1, 0, 0, 0, 16'h5555};
    vecs[7]  = '{1, 1, 16'h7777, 16'h0303, 1, 0, 0, 1, 16'h7777};
    vecs[8]  = '{0, 0, 16'h8888, 16'h0404, 0, 0, 0, 1, 16'h8888};
    vecs[9]  = '{0, 1, 16'h0505, 16'h9999, 0, 1, 1, 0, 16'h8888};
    vecs[10] = '{1, 1, 16'h0606, 16'hAAAA, 0, 1, 1, 1, 16'hAAAA};
    vecs[11] = '{1, 0, 16'hCCCC, 16'hBBBB, 1, 0, 0, 1, 16'hBBBB};

    // Directed table from reset.
    do_reset(1'b1);
    for (int i = 0; i < 12; i++) begin
      Req0 = vecs[i].r0; Req1 = vecs[i].r1; Data0 = vecs[i].d0; Data1 = vecs[i].d1;
      step();
      chk($sformatf("vec%0d_gnt0", i), Gnt0, vecs[i].g0);
      chk($sformatf("vec%0d_gnt1", i), Gnt1, vecs[i].g1);
      chk($sformatf("vec%0d_sel", i), Sel, vecs[i].sel);
      chk($sformatf("vec%0d_valid", i), BusValid, vecs[i].valid);
      chk($sformatf("vec%0d_bus", i), BusOut, vecs[i].bus);
    end

    // Tie from reset: Req0 first, then alternate every MAX_HOLD cycles.
    do_reset(1'b0);
    Req0 = 1'b1; Req1 = 1'b1;
    for (int i = 0; i < 3 * MAX_HOLD; i++) begin
      step();
      chk($sformatf("rr_gnt0_c%0d", i), Gnt0, ((i / MAX_HOLD) % 2) == 0);
      chk($sformatf("rr_gnt1_c%0d", i), Gnt1, ((i / MAX_HOLD) % 2) == 1);
    end

    // Handoff on release, then a full fresh tenure for the new owner.
    do_reset(1'b0);
    Req0 = 1'b1; Req1 = 1'b1;
    for (int i = 0; i < 3; i++) step();
    chk("ho_pre_gnt0", Gnt0, 1);
    Req0 = 1'b0;
    step();
    chk("ho_gnt1", Gnt1, 1);
    chk("ho_sel", Sel, 1);
    chk("ho_gnt0", Gnt0, 0);
    Req0 = 1'b1;
    for (int i = 0; i < MAX_HOLD - 1; i++) begin
      step();
      chk($sformatf("ho_hold_c%0d", i), Gnt1, 1);
    end
    step();
    chk("ho_preempt_gnt0", Gnt0, 1);

    // Lone requester keeps the bus indefinitely.
    do_reset(1'b0);
    Req1 = 1'b1;
    for (int i = 0; i < 50; i++) begin
      Data1 = 16'($urandom);
      step();
      chk($sformatf("lone_gnt1_c%0d", i), Gnt1, 1);
    end
    Req1 = 1'b0;
    last_d1 = 16'hBEEF;
    Data1 = last_d1;
    step();
    chk("lone_rel_gnt1", Gnt1, 0);
    chk("lone_rel_valid", BusValid, 1);
    chk("lone_rel_bus", BusOut, last_d1);
    Data1 = 16'h1234;
    step();
    chk("lone_idle_valid", BusValid, 0);
    chk("lone_idle_bus", BusOut, last_d1);

    // Asynchronous reset between edges.
    do_reset(1'b0);
    Req0 = 1'b1; Data0 = 16'h5A5A;
    step(); step();
    chk("ar_pre_valid", BusValid, 1);
    chk("ar_pre_bus", BusOut, 16'h5A5A);
    #3 Resetn = 1'b0;
    #1;
    chk("ar_gnt0", Gnt0, 0);
    chk("ar_sel", Sel, 0);
    chk("ar_valid", BusValid, 0);
    chk("ar_bus", BusOut, 0);
    Req0 = 1'b1; Req1 = 1'b1;
    @(posedge Clock);
    #2 Resetn = 1'b1;
    model_reset();
    step();
    chk("ar_tie_gnt0", Gnt0, 1);
    chk("ar_tie_gnt1", Gnt1, 0);

    // Random traffic against the model.
    do_reset(1'b0);
    wait0 = 0; wait1 = 0;
    for (int i = 0; i < 10000; i++) begin
      logic r0, r1;
      if ($urandom_range(5) == 0) Req0 = ~Req0;
      if ($urandom_range(5) == 0) Req1 = ~Req1;
      Data0 = 16'($urandom);
      Data1 = 16'($urandom);
      r0 = Req0; r1 = Req1;
      step();
      chk("rnd_gnt0", Gnt0, m_owner == 0);
      chk("rnd_gnt1", Gnt1, m_owner == 1);
      chk("rnd_sel", Sel, m_owner == 1);
      chk("rnd_valid", BusValid, m_valid);
      if (m_valid) chk("rnd_bus", BusOut, m_bus);
      chk("rnd_onehot", Gnt0 & Gnt1, 0);
      wait0 = (r0 && !Gnt0) ? wait0 + 1 : 0;
      wait1 = (r1 && !Gnt1) ? wait1 + 1 : 0;
      chk("rnd_wait0_bound", wait0 <= MAX_HOLD + 1, 1);
      chk("rnd_wait1_bound", wait1 <= MAX_HOLD + 1, 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
